// File: rtl/digit_sched_pkg.sv
// digit_sched_pkg
// Shared types and constants for the digit-recognition frame sequencer:
//   state_e        - sequencer states
//   owner_e        - which engine owns the shared border-RAM port
//   FRAME_FEATURE  - frame phase in which the feature/readout frame runs
//   sat_cnt()      - clamps a 4-bit count to an upper limit
package digit_sched_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT_VS = 3'd1,
    PROJ    = 3'd2,
    FEATURE = 3'd3,
    RESULT  = 3'd4
  } state_e;

  typedef enum logic {
    OWN_PROJ = 1'b0,
    OWN_REC  = 1'b1
  } owner_e;

  localparam logic [1:0] FRAME_FEATURE = 2'd2;

  function automatic logic [3:0] sat_cnt(input logic [3:0] val, input logic [3:0] lim);
    logic [3:0] res;
    if (val > lim) begin
      res = lim;
    end else begin
      res = val;
    end
    return res;
  endfunction

endpackage

// File: rtl/border_ram_arb.sv
// border_ram_arb
// Combinational mux for the shared project-border RAM port.
// Ports:
//   owner_rec      in   1 = recognizer owns the port, 0 = projection engine
//   proj_ram_we    in   projection write enable
//   proj_ram_addr  in   projection write address
//   proj_ram_din   in   projection write data
//   rec_ram_addr   in   recognizer read address
//   ram_we/addr/din out muxed RAM port
//   conflict       out  projection write attempted while recognizer owns port
module border_ram_arb #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 11
) (
  input  logic              owner_rec,
  input  logic              proj_ram_we,
  input  logic [ADDR_W-1:0] proj_ram_addr,
  input  logic [DATA_W-1:0] proj_ram_din,
  input  logic [ADDR_W-1:0] rec_ram_addr,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              conflict
);

  // Port mux: recognizer is read-only, so its write lines are forced low and
  // any projection write in that mode is dropped and flagged.
  always_comb begin
    if (owner_rec) begin
      ram_we   = 1'b0;
      ram_addr = rec_ram_addr;
      ram_din  = '0;
      conflict = proj_ram_we;
    end else begin
      ram_we   = proj_ram_we;
      ram_addr = proj_ram_addr;
      ram_din  = proj_ram_din;
      conflict = 1'b0;
    end
  end

endmodule

// File: rtl/digit_frame_sched.sv
// digit_frame_sched
// Frame-level sequencer for the digit-recognition pipeline. Tracks the frame
// phase, latches the detected grid size, arbitrates the border RAM between
// projection (writer) and recognizer (reader) and hands the recognized digit
// word to the user over valid/ready.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   start, cont                run control (cont = rerun after each handshake)
//   vsync                      frame sync level (synchronized internally)
//   proj_done, num_row_in/col  projection completion and grid size
//   proj_ram_*, rec_ram_addr   RAM requests from the two engines
//   ram_we/addr/din            arbitrated RAM port
//   frame_cnt, project_done_flag, num_row, num_col  recognizer controls
//   digit_in/out/vld/rdy       result capture and handshake
//   busy, err, ram_conflict    status (err/ram_conflict sticky until start)
// Optional build macro DIGIT_SCHED_STAT_EN adds run_cnt / err_cnt outputs.
module digit_frame_sched
  import digit_sched_pkg::*;
#(
  parameter int MAX_ROW        = 4,
  parameter int MAX_COL        = 8,
  parameter int ADDR_W         = 11,
  parameter int DIGIT_W        = 16,
  parameter int TIMEOUT_FRAMES = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               cont,
  input  logic               vsync,
  input  logic               proj_done,
  input  logic [3:0]         num_row_in,
  input  logic [3:0]         num_col_in,
  input  logic               proj_ram_we,
  input  logic [ADDR_W-1:0]  proj_ram_addr,
  input  logic [10:0]        proj_ram_din,
  input  logic [ADDR_W-1:0]  rec_ram_addr,
  output logic               ram_we,
  output logic [ADDR_W-1:0]  ram_addr,
  output logic [10:0]        ram_din,
  output logic [1:0]         frame_cnt,
  output logic               project_done_flag,
  output logic [3:0]         num_row,
  output logic [3:0]         num_col,
  input  logic [DIGIT_W-1:0] digit_in,
  output logic [DIGIT_W-1:0] digit_out,
  output logic               digit_vld,
  input  logic               digit_rdy,
  output logic               busy,
  output logic               err,
  output logic               ram_conflict
`ifdef DIGIT_SCHED_STAT_EN
  ,
  output logic [15:0]        run_cnt,
  output logic [15:0]        err_cnt
`endif
);

  localparam int              TO_W    = $clog2(TIMEOUT_FRAMES + 1);
  localparam logic [TO_W-1:0] TO_LIM  = TO_W'(TIMEOUT_FRAMES);
  localparam logic [3:0]      ROW_LIM = 4'(MAX_ROW);
  localparam logic [3:0]      COL_LIM = 4'(MAX_COL);

  logic vs_s1_q, vs_s2_q, vs_prev_q;
  logic vs_rise_s;

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [1:0]        frame_cnt_q, frame_cnt_d;
  logic              flag_q, flag_d;
  logic [3:0]        num_row_q, num_row_d;
  logic [3:0]        num_col_q, num_col_d;
  logic [DIGIT_W-1:0] digit_out_q, digit_out_d;
  logic              digit_vld_q, digit_vld_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic              conflict_q, conflict_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic              conflict_s;

  // Two-flop synchronizer plus previous-value flop for vsync edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_s1_q   <= 1'b0;
      vs_s2_q   <= 1'b0;
      vs_prev_q <= 1'b0;
    end else begin
      vs_s1_q   <= vsync;
      vs_s2_q   <= vs_s1_q;
      vs_prev_q <= vs_s2_q;
    end
  end

  assign vs_rise_s = vs_s2_q & ~vs_prev_q;

  border_ram_arb #(
    .ADDR_W (ADDR_W),
    .DATA_W (11)
  ) u_arb (
    .owner_rec     (owner_q == OWN_REC),
    .proj_ram_we   (proj_ram_we),
    .proj_ram_addr (proj_ram_addr),
    .proj_ram_din  (proj_ram_din),
    .rec_ram_addr  (rec_ram_addr),
    .ram_we        (ram_we),
    .ram_addr      (ram_addr),
    .ram_din       (ram_din),
    .conflict      (conflict_s)
  );

  // Next-state and next-output computation for the sequencer.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    frame_cnt_d = frame_cnt_q;
    flag_d      = flag_q;
    num_row_d   = num_row_q;
    num_col_d   = num_col_q;
    digit_out_d = digit_out_q;
    digit_vld_d = digit_vld_q;
    err_d       = err_q;
    to_cnt_d    = to_cnt_q;

    // Sticky conflict: cleared by an accepted start, set by any dropped write.
    if (state_q == IDLE && start) begin
      conflict_d = 1'b0;
    end else begin
      conflict_d = conflict_q;
    end
    if (conflict_s) begin
      conflict_d = 1'b1;
    end else begin
      conflict_d = conflict_d;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = WAIT_VS;
          err_d    = 1'b0;
          to_cnt_d = '0;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT_VS: begin
        if (vs_rise_s) begin
          state_d     = PROJ;
          frame_cnt_d = 2'd0;
          flag_d      = 1'b0;
          owner_d     = OWN_PROJ;
          // Fresh timeout budget for each run, including automatic reruns.
          to_cnt_d    = '0;
        end else begin
          state_d = WAIT_VS;
        end
      end
      PROJ: begin
        // proj_done takes priority over a simultaneous vsync edge.
        if (proj_done) begin
          num_row_d = sat_cnt(num_row_in, ROW_LIM);
          num_col_d = sat_cnt(num_col_in, COL_LIM);
          if (num_row_in == 4'd0 || num_col_in == 4'd0) begin
            state_d = IDLE;
            err_d   = 1'b1;
          end else begin
            flag_d  = 1'b1;
            owner_d = OWN_REC;
          end
        end else if (vs_rise_s) begin
          if (flag_q) begin
            if (frame_cnt_q == FRAME_FEATURE - 2'd1) begin
              frame_cnt_d = FRAME_FEATURE;
              state_d     = FEATURE;
            end else begin
              frame_cnt_d = frame_cnt_q + 2'd1;
            end
          end else begin
            if (to_cnt_q == TO_LIM - TO_W'(1)) begin
              to_cnt_d = TO_LIM;
              state_d  = IDLE;
              err_d    = 1'b1;
            end else begin
              to_cnt_d = to_cnt_q + TO_W'(1);
            end
          end
        end else begin
          state_d = PROJ;
        end
      end
      FEATURE: begin
        if (vs_rise_s) begin
          digit_out_d = digit_in;
          digit_vld_d = 1'b1;
          flag_d      = 1'b0;
          frame_cnt_d = 2'd0;
          state_d     = RESULT;
        end else begin
          state_d = FEATURE;
        end
      end
      RESULT: begin
        // vsync edges are ignored while the result waits for acceptance.
        if (digit_rdy) begin
          digit_vld_d = 1'b0;
          if (cont) begin
            state_d = WAIT_VS;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = RESULT;
        end
      end
      default: begin
        state_d     = IDLE;
        digit_vld_d = 1'b0;
        flag_d      = 1'b0;
        frame_cnt_d = 2'd0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_q     <= OWN_PROJ;
      frame_cnt_q <= 2'd0;
      flag_q      <= 1'b0;
      num_row_q   <= 4'd0;
      num_col_q   <= 4'd0;
      digit_out_q <= '0;
      digit_vld_q <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      conflict_q  <= 1'b0;
      to_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      frame_cnt_q <= frame_cnt_d;
      flag_q      <= flag_d;
      num_row_q   <= num_row_d;
      num_col_q   <= num_col_d;
      digit_out_q <= digit_out_d;
      digit_vld_q <= digit_vld_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      conflict_q  <= conflict_d;
      to_cnt_q    <= to_cnt_d;
    end
  end

  assign frame_cnt         = frame_cnt_q;
  assign project_done_flag = flag_q;
  assign num_row           = num_row_q;
  assign num_col           = num_col_q;
  assign digit_out         = digit_out_q;
  assign digit_vld         = digit_vld_q;
  assign busy              = busy_q;
  assign err               = err_q;
  assign ram_conflict      = conflict_q;

`ifdef DIGIT_SCHED_STAT_EN
  logic        hs_evt_s, err_evt_s;
  logic [15:0] run_cnt_q, err_cnt_q;

  assign hs_evt_s  = (state_q == RESULT) && digit_rdy;
  assign err_evt_s = (state_q == PROJ) && (state_d == IDLE);

  // Saturating run/error statistics; survive start, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_cnt_q <= 16'd0;
      err_cnt_q <= 16'd0;
    end else begin
      if (hs_evt_s && run_cnt_q != 16'hFFFF) begin
        run_cnt_q <= run_cnt_q + 16'd1;
      end else begin
        run_cnt_q <= run_cnt_q;
      end
      if (err_evt_s && err_cnt_q != 16'hFFFF) begin
        err_cnt_q <= err_cnt_q + 16'd1;
      end else begin
        err_cnt_q <= err_cnt_q;
      end
    end
  end

  assign run_cnt = run_cnt_q;
  assign err_cnt = err_cnt_q;
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule
